rot_frame_rx: RTL

- Receive-side counterpart of the SRAM rotate adapter's read phase.
- Captures the rotated pixel stream (pixel byte, row-start marker, frame-end marker) and re-establishes column/row position.
- Checks framing against the configured image geometry and produces a per-row byte sum.
- Buffers pixels in a small FIFO and presents them to the downstream consumer over a valid/ready interface with row/frame last flags.

---
 rtl/rot_frame_rx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/rot_frame_rx.sv
// rot_frame_rx: receive side of the rotate adapter read phase.
// Recovers pixel position, checks framing, sums rows and queues pixels for a valid/ready consumer.
module rot_frame_rx #(
    parameter int unsigned IMG_W      = 1024,
    parameter int unsigned IMG_H      = 1024,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_en,
    input  logic [7:0]  pix_in,
    input  logic        row_start,
    input  logic        frame_end,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last_col,
    output logic        m_last_frame,
    output logic [17:0] row_sum,
    output logic        row_sum_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic        overflow
);
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = 18;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic       last_frame;
        logic       last_col;
        logic [7:0] pixel;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_RECV,
        ST_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, p_col;
    logic [ROW_W-1:0]    row_q, p_row, row_q_inc, p_row_inc;
    logic [SUM_W-1:0]    acc_q, acc_sum;
    logic                resync, miss_sof, acc_clr;
    logic                pos_last_col, pos_last_frame;
    logic                accept, err_set, clr_sticky, frame_done_d;

    fifo_entry_t         mem_q [FIFO_DEPTH];
    fifo_entry_t         head_q, wr_entry;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    fifo_cnt_q, avail;
    logic                pop, full, wr_ok, drop;

    assign row_q_inc      = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    assign p_row_inc      = (p_row == ROW_LAST) ? '0 : p_row + ROW_W'(1);
    assign pos_last_col   = (p_col == COL_LAST);
    assign pos_last_frame = pos_last_col && (p_row == ROW_LAST);
    assign acc_clr        = resync || (state_q == ST_WAIT_SOF);
    assign acc_sum        = (acc_clr ? '0 : acc_q) + SUM_W'(pix_in);

    // Position of the pixel on the bus this cycle, including row_start resync.
    always_comb begin
        p_col    = col_q;
        p_row    = row_q;
        resync   = 1'b0;
        miss_sof = 1'b0;
        if (state_q == ST_WAIT_SOF) begin
            p_col = '0;
            p_row = '0;
        end else if (row_start && (col_q != '0)) begin
            resync = 1'b1;
            p_col  = '0;
            p_row  = row_q_inc;
        end else if (!row_start && (col_q == '0)) begin
            miss_sof = 1'b1;
        end
    end

    // Frame FSM: next state and control strobes.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        err_set      = 1'b0;
        clr_sticky   = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_en) begin
                    state_d    = ST_WAIT_SOF;
                    clr_sticky = 1'b1;
                end
            end
            ST_WAIT_SOF: begin
                if (!rx_en) begin
                    state_d = ST_IDLE;
                end else if (row_start) begin
                    accept  = 1'b1;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                accept  = rx_en;
                err_set = rx_en && (resync || miss_sof);
                if (rx_en && pos_last_frame) begin
                    state_d = ST_DRAIN;
                end else if (frame_end) begin
                    err_set = 1'b1;
                    state_d = ST_DRAIN;
                end else if (!rx_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (fifo_cnt_q == '0) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Position counters, row accumulator and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q         <= '0;
            row_q         <= '0;
            acc_q         <= '0;
            row_sum       <= '0;
            row_sum_valid <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            row_sum_valid <= 1'b0;
            frame_done    <= frame_done_d;
            if (clr_sticky) begin
                frame_err <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (err_set) frame_err <= 1'b1;
                if (drop)    overflow  <= 1'b1;
            end
            if (accept) begin
                col_q <= pos_last_col ? '0 : p_col + COL_W'(1);
                row_q <= pos_last_col ? p_row_inc : p_row;
                if (pos_last_col) begin
                    row_sum       <= acc_sum;
                    row_sum_valid <= 1'b1;
                    acc_q         <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

    // Output FIFO; the head register only sees entries written on an earlier edge.
    assign pop      = m_valid && m_ready;
    assign full     = (fifo_cnt_q == CNT_FULL);
    assign wr_ok    = accept && (!full || pop);
    assign drop     = accept && full && !pop;
    assign avail    = fifo_cnt_q - CNT_W'(pop);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign wr_entry = '{last_frame: pos_last_frame, last_col: pos_last_col, pixel: pix_in};

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            head_q     <= '0;
            m_valid    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q <= rd_ptr_d;
            unique case ({wr_ok, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            m_valid <= (avail != '0);
            head_q  <= (avail != '0) ? mem_q[rd_ptr_d] : '0;
        end
    end

    assign m_data       = head_q.pixel;
    assign m_last_col   = head_q.last_col;
    assign m_last_frame = head_q.last_frame;

endmodule
